iomem_arbiter: RTL and testbench

- Shares the single PicoSoC iomem slave bus (GPIO at 0x03xx_xxxx, MMIO at 0x06xx_xxxx) between two requesters.
- m0 is the picosoc CPU iomem port; m1 is an auxiliary master such as a debug or UART bridge.
- Round-robin arbitration, native valid/ready handshake on both sides.
- A bus-timeout watchdog completes hung transactions itself with a fixed read value and an error pulse.

---
 rtl/iomem_pkg.sv | 24 ++
 rtl/iomem_timeout_ctr.sv | 32 +++
 rtl/iomem_arbiter.sv | 150 +++++++++++++++
 tb/tb_iomem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared types and constants for the PicoSoC iomem two-master arbiter.
package iomem_pkg;

  localparam int unsigned IOMEM_AW = 32;
  localparam int unsigned IOMEM_DW = 32;
  localparam int unsigned IOMEM_SW = 4;

  localparam int unsigned        IOMEM_TIMEOUT_CYCLES = 256;
  localparam logic [IOMEM_DW-1:0] IOMEM_TIMEOUT_RDATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Request payload forwarded from the granted master to the target.
  typedef struct packed {
    logic [IOMEM_SW-1:0] wstrb;
    logic [IOMEM_AW-1:0] addr;
    logic [IOMEM_DW-1:0] wdata;
  } iomem_req_t;

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Bus watchdog counter: counts granted cycles, flags the last allowed one.
module iomem_timeout_ctr
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = IOMEM_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count while enabled; holds at LAST so it can never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the PicoSoC iomem slave bus between two masters,
// with a watchdog that force-completes hung transactions.
// Optional: define IOMEM_ARB_LOCK_EN to add m1_lock (m1 bus locking).
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYCLES = IOMEM_TIMEOUT_CYCLES,
  parameter logic [IOMEM_DW-1:0] TIMEOUT_RDATA  = IOMEM_TIMEOUT_RDATA
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [IOMEM_SW-1:0] m0_wstrb,
  input  logic [IOMEM_AW-1:0] m0_addr,
  input  logic [IOMEM_DW-1:0] m0_wdata,
  output logic [IOMEM_DW-1:0] m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [IOMEM_SW-1:0] m1_wstrb,
  input  logic [IOMEM_AW-1:0] m1_addr,
  input  logic [IOMEM_DW-1:0] m1_wdata,
  output logic [IOMEM_DW-1:0] m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [IOMEM_SW-1:0] s_wstrb,
  output logic [IOMEM_AW-1:0] s_addr,
  output logic [IOMEM_DW-1:0] s_wdata,
  input  logic [IOMEM_DW-1:0] s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
`ifdef IOMEM_ARB_LOCK_EN
  ,
  input  logic                m1_lock
`endif
);

  arb_state_t state;
  logic       rr_last;     // 1: m1 was served last, m0 wins the next tie
  iomem_req_t sel_req;
  logic       sel_valid;
  logic       expire;
  logic       forced;
  logic       complete;
  logic       m0_block;
  logic       want0;

  iomem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .expire (expire)
  );

`ifdef IOMEM_ARB_LOCK_EN
  logic lock_hold;

  assign m0_block = lock_hold && m1_lock;

  // Remember an m1 lock across the completion bubble until m1 releases it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_hold <= 1'b0;
    end else if ((state == IDLE) && !m1_lock) begin
      lock_hold <= 1'b0;
    end else if ((state == GNT1) && complete) begin
      lock_hold <= m1_lock;
    end
  end
`else
  assign m0_block = 1'b0;
`endif

  assign want0 = m0_valid && !m0_block;

  // Select the owner's request and build the completion/timeout strobes.
  always_comb begin
    sel_req   = '0;
    sel_valid = 1'b0;
    unique case (state)
      GNT0: begin
        sel_req   = '{wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
        sel_valid = m0_valid;
      end
      GNT1: begin
        sel_req   = '{wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};
        sel_valid = m1_valid;
      end
      default: ;
    endcase
    forced   = sel_valid && expire && !s_ready;
    complete = sel_valid && (s_ready || expire);
  end

  // Bus-facing and master-facing datapath; the idle master sees zeros.
  always_comb begin
    s_valid     = sel_valid && !expire;
    s_wstrb     = sel_req.wstrb;
    s_addr      = sel_req.addr;
    s_wdata     = sel_req.wdata;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    timeout_err = forced;
    grant       = 2'b00;
    if (state == GNT0) begin
      grant    = 2'b01;
      m0_ready = complete;
      m0_rdata = forced ? TIMEOUT_RDATA : s_rdata;
    end else if (state == GNT1) begin
      grant    = 2'b10;
      m1_ready = complete;
      m1_rdata = forced ? TIMEOUT_RDATA : s_rdata;
    end
  end

  // Arbitration FSM with a mandatory IDLE bubble after every completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (want0 && m1_valid) begin
            state <= rr_last ? GNT0 : GNT1;
          end else if (want0) begin
            state <= GNT0;
          end else if (m1_valid) begin
            state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (complete || !sel_valid) begin
            state <= IDLE;
          end
          if (complete) begin
            rr_last <= (state == GNT1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed self-checking bench for iomem_arbiter (TIMEOUT_CYCLES = 8).
// Define IOMEM_ARB_LOCK_EN to also exercise the m1 lock sequence.
module tb_iomem_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;
`ifdef IOMEM_ARB_LOCK_EN
  logic        m1_lock;
`endif

  int total;
  int passes;

  iomem_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
`ifdef IOMEM_ARB_LOCK_EN
    ,
    .m1_lock     (m1_lock)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    total = 0;
    passes = 0;
    resetn = 1'b0;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = '0; m1_wdata = '0;
    s_ready = 1'b1; s_rdata = 32'h5555_5555;
`ifdef IOMEM_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif

    // Reset: everything zero even with a request and a ready target
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_ready", 32'(m0_ready), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    @(negedge clk);
    resetn = 1'b1;

    // Simultaneous requests after reset: m0 first, bubble, then m1
    tick;
    m0_valid = 1'b1; m0_addr = 32'h0300_0004;
    m1_valid = 1'b1; m1_addr = 32'h0600_0008;
    settle;
    chk("tie_idle_grant", 32'(grant), 32'h0);
    tick;
    chk("tie_first_grant", 32'(grant), 32'h1);
    chk("tie_first_s_valid", 32'(s_valid), 32'h1);
    chk("tie_first_s_addr", s_addr, 32'h0300_0004);
    s_ready = 1'b1; s_rdata = 32'h0000_0011;
    settle;
    chk("tie_m0_ready", 32'(m0_ready), 32'h1);
    chk("tie_m0_rdata", m0_rdata, 32'h0000_0011);
    chk("tie_m1_ready_low", 32'(m1_ready), 32'h0);
    chk("tie_m1_rdata_zero", m1_rdata, 32'h0);
    tick;
    m0_valid = 1'b0;
    settle;
    chk("bubble_grant", 32'(grant), 32'h0);
    chk("bubble_s_valid", 32'(s_valid), 32'h0);
    chk("bubble_m1_ready", 32'(m1_ready), 32'h0);
    tick;
    s_rdata = 32'h0000_0022;
    settle;
    chk("tie_second_grant", 32'(grant), 32'h2);
    chk("tie_second_s_addr", s_addr, 32'h0600_0008);
    chk("tie_m1_ready", 32'(m1_ready), 32'h1);
    chk("tie_m1_rdata", m1_rdata, 32'h0000_0022);
    chk("tie_m0_ready_low", 32'(m0_ready), 32'h0);
    tick;
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    settle;
    chk("tie_end_grant", 32'(grant), 32'h0);

    // m0 read of GPIO, target answers on the third granted cycle
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
    settle;
    chk("rd_decide_grant", 32'(grant), 32'h0);
    tick;
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_s_valid", 32'(s_valid), 32'h1);
    chk("rd_s_addr", s_addr, 32'h0300_0000);
    chk("rd_s_wstrb", 32'(s_wstrb), 32'h0);
    chk("rd_wait_ready", 32'(m0_ready), 32'h0);
    tick;
    tick;
    s_ready = 1'b1; s_rdata = 32'h0000_00A5;
    settle;
    chk("rd_m0_ready", 32'(m0_ready), 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'h0000_00A5);
    chk("rd_m1_ready", 32'(m1_ready), 32'h0);
    chk("rd_no_err", 32'(timeout_err), 32'h0);
    tick;
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    settle;
    chk("rd_end_ready", 32'(m0_ready), 32'h0);

    // Tie after m0 was last served: m1 write wins
    m0_valid = 1'b1; m0_addr = 32'h0300_0010;
    m1_valid = 1'b1; m1_addr = 32'h0600_0000; m1_wstrb = 4'b0011; m1_wdata = 32'h0000_1234;
    tick;
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_s_addr", s_addr, 32'h0600_0000);
    chk("wr_s_wstrb", 32'(s_wstrb), 32'h3);
    chk("wr_s_wdata", s_wdata, 32'h0000_1234);
    chk("wr_wait_ready", 32'(m1_ready), 32'h0);
    s_ready = 1'b1; s_rdata = 32'h0000_DDDD;
    settle;
    chk("wr_m1_ready", 32'(m1_ready), 32'h1);
    chk("wr_m0_ready_low", 32'(m0_ready), 32'h0);
    chk("wr_m0_rdata_zero", m0_rdata, 32'h0);
    tick;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_wdata = '0; s_ready = 1'b0;
    settle;
    chk("wr_bubble_grant", 32'(grant), 32'h0);
    tick;
    chk("wr_then_m0_grant", 32'(grant), 32'h1);
    chk("wr_then_m0_addr", s_addr, 32'h0300_0010);
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    settle;
    chk("wr_then_m0_rdata", m0_rdata, 32'h0000_0077);
    tick;
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;

    // Watchdog: target never answers, forced completion on the 8th cycle
    m0_valid = 1'b1; m0_addr = 32'h0300_0020;
    for (int i = 1; i <= 7; i++) begin
      tick;
      chk("to_wait_s_valid", 32'(s_valid), 32'h1);
      chk("to_wait_ready", 32'(m0_ready), 32'h0);
      chk("to_wait_err", 32'(timeout_err), 32'h0);
    end
    tick;
    chk("to_grant", 32'(grant), 32'h1);
    chk("to_s_valid_low", 32'(s_valid), 32'h0);
    chk("to_m0_ready", 32'(m0_ready), 32'h1);
    chk("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("to_err", 32'(timeout_err), 32'h1);
    tick;
    m0_valid = 1'b0;
    settle;
    chk("to_after_grant", 32'(grant), 32'h0);
    chk("to_after_err", 32'(timeout_err), 32'h0);
    chk("to_after_ready", 32'(m0_ready), 32'h0);

    // Ready exactly on the 8th cycle beats the watchdog
    m0_valid = 1'b1;
    for (int i = 1; i <= 7; i++) tick;
    tick;
    s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
    settle;
    chk("race_m0_ready", 32'(m0_ready), 32'h1);
    chk("race_m0_rdata", m0_rdata, 32'hCAFE_0001);
    chk("race_no_err", 32'(timeout_err), 32'h0);
    tick;
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;

    // Master drops valid while granted: silent return to IDLE
    m1_valid = 1'b1; m1_addr = 32'h0600_0004;
    tick;
    chk("drop_grant", 32'(grant), 32'h2);
    m1_valid = 1'b0;
    settle;
    chk("drop_s_valid", 32'(s_valid), 32'h0);
    chk("drop_m1_ready", 32'(m1_ready), 32'h0);
    tick;
    chk("drop_idle", 32'(grant), 32'h0);
    chk("drop_no_err", 32'(timeout_err), 32'h0);

    // Reset during GNT1 aborts at once; pending m1 is re-arbitrated
    m1_valid = 1'b1; m1_addr = 32'h0600_0008;
    tick;
    chk("mrst_pre_grant", 32'(grant), 32'h2);
    resetn = 1'b0; s_ready = 1'b1; s_rdata = 32'h0000_0001;
    settle;
    chk("mrst_grant", 32'(grant), 32'h0);
    chk("mrst_s_valid", 32'(s_valid), 32'h0);
    chk("mrst_s_addr", s_addr, 32'h0);
    chk("mrst_m1_ready", 32'(m1_ready), 32'h0);
    chk("mrst_m1_rdata", m1_rdata, 32'h0);
    tick;
    resetn = 1'b1; s_ready = 1'b0;
    settle;
    chk("mrst_release_idle", 32'(grant), 32'h0);
    tick;
    chk("mrst_regrant", 32'(grant), 32'h2);
    chk("mrst_regrant_addr", s_addr, 32'h0600_0008);
    s_ready = 1'b1; s_rdata = 32'h0000_0099;
    settle;
    chk("mrst_m1_ready_after", 32'(m1_ready), 32'h1);
    tick;
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;

`ifdef IOMEM_ARB_LOCK_EN
    // m1 locks the bus; m0 starves until the lock drops in IDLE
    m1_lock = 1'b1; m1_valid = 1'b1; m1_addr = 32'h0600_0010; s_ready = 1'b1;
    tick;
    chk("lock_first_grant", 32'(grant), 32'h2);
    m0_valid = 1'b1; m0_addr = 32'h0300_0030;
    tick;
    chk("lock_bubble1", 32'(grant), 32'h0);
    tick;
    chk("lock_grant2", 32'(grant), 32'h2);
    tick;
    chk("lock_bubble2", 32'(grant), 32'h0);
    tick;
    chk("lock_grant3", 32'(grant), 32'h2);
    tick;
    m1_lock = 1'b0;
    tick;
    chk("unlock_m0_grant", 32'(grant), 32'h1);
    tick;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
`endif

    tick;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
